// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue-stage interlock for the in-order integer/FP pipeline.
// Tracks outstanding GPR, FPR and EFLAGS writes. Issue is granted only when
// the presented op has no RAW/WAW hazard, with writeback bypassed into the
// check. Ordering-sensitive ops wait for an empty scoreboard, and a flush
// blocks issue for FLUSH_CYC cycles.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   iss_valid, iss_rut        op presented for issue and its register usage
//   iss_serial                op may only issue with nothing pending
//   iss_ready                 issue permitted this cycle (combinational)
//   wb_g_valid/wb_g_idx       GPR writeback
//   wb_f_valid/wb_f_idx       FPR writeback
//   wb_ef_valid               EFLAGS writeback
//   flush                     kill all in-flight ops
//   busy_g/busy_f/busy_ef     registered pending bits
//   stall_cnt                 saturating count of stalled issue cycles

package hazard_scoreboard_pkg;

    localparam int unsigned RUT_IDX_W = 5;

    // Register-usage descriptor of the op waiting to issue.
    typedef struct packed {
        logic [RUT_IDX_W-1:0] d;
        logic [RUT_IDX_W-1:0] s;
        logic [RUT_IDX_W-1:0] t;
        logic                 from_gd;
        logic                 from_fd;
        logic                 to_gd;
        logic                 to_fd;
        logic                 from_gs;
        logic                 from_fs;
        logic                 from_gt;
        logic                 from_ft;
        logic                 from_ef;
        logic                 to_ef;
    } rut_t;

endpackage

module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NGPR      = 16,
    parameter int unsigned NFPR      = 16,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  rut_t              iss_rut,
    input  logic              iss_serial,
    output logic              iss_ready,
    input  logic              wb_g_valid,
    input  logic [IDX_W-1:0]  wb_g_idx,
    input  logic              wb_f_valid,
    input  logic [IDX_W-1:0]  wb_f_idx,
    input  logic              wb_ef_valid,
    input  logic              flush,
    output logic [NGPR-1:0]   busy_g,
    output logic [NFPR-1:0]   busy_f,
    output logic              busy_ef,
    output logic [31:0]       stall_cnt
);

    localparam int unsigned TMR_W = 3;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [NGPR-1:0]   pend_g_q, pend_g_d;
    logic [NFPR-1:0]   pend_f_q, pend_f_d;
    logic              pend_ef_q, pend_ef_d;
    logic [31:0]       stall_q, stall_d;

    logic [IDX_W-1:0]  d_idx, s_idx, t_idx;
    logic [NGPR-1:0]   wb_g_mask, dsel_g, ssel_g, tsel_g;
    logic [NFPR-1:0]   wb_f_mask, dsel_f, ssel_f, tsel_f;
    logic [NGPR-1:0]   eff_g;
    logic [NFPR-1:0]   eff_f;
    logic              eff_ef;
    logic              hazard;
    logic              all_clear;
    logic              issue_fire;
    logic              unused_rut_bits;

    assign d_idx = iss_rut.d[IDX_W-1:0];
    assign s_idx = iss_rut.s[IDX_W-1:0];
    assign t_idx = iss_rut.t[IDX_W-1:0];

    // Upper descriptor index bits are architecturally don't-care here.
    assign unused_rut_bits = ^iss_rut;

    // One-hot decode of operand indices and writeback targets.
    always_comb begin
        wb_g_mask = '0;
        dsel_g    = '0;
        ssel_g    = '0;
        tsel_g    = '0;
        wb_f_mask = '0;
        dsel_f    = '0;
        ssel_f    = '0;
        tsel_f    = '0;
        for (int unsigned i = 0; i < NGPR; i++) begin
            wb_g_mask[i] = wb_g_valid && (wb_g_idx == IDX_W'(i));
            dsel_g[i]    = (d_idx == IDX_W'(i));
            ssel_g[i]    = (s_idx == IDX_W'(i));
            tsel_g[i]    = (t_idx == IDX_W'(i));
        end
        for (int unsigned i = 0; i < NFPR; i++) begin
            wb_f_mask[i] = wb_f_valid && (wb_f_idx == IDX_W'(i));
            dsel_f[i]    = (d_idx == IDX_W'(i));
            ssel_f[i]    = (s_idx == IDX_W'(i));
            tsel_f[i]    = (t_idx == IDX_W'(i));
        end
    end

    // Same-cycle writeback bypasses into the hazard check.
    assign eff_g  = pend_g_q & ~wb_g_mask;
    assign eff_f  = pend_f_q & ~wb_f_mask;
    assign eff_ef = pend_ef_q & ~wb_ef_valid;

    always_comb begin
        hazard = 1'b0;
        if ((iss_rut.from_gd || iss_rut.to_gd) && |(eff_g & dsel_g)) hazard = 1'b1;
        if ((iss_rut.from_fd || iss_rut.to_fd) && |(eff_f & dsel_f)) hazard = 1'b1;
        if (iss_rut.from_gs && |(eff_g & ssel_g))                    hazard = 1'b1;
        if (iss_rut.from_fs && |(eff_f & ssel_f))                    hazard = 1'b1;
        if (iss_rut.from_gt && |(eff_g & tsel_g))                    hazard = 1'b1;
        if (iss_rut.from_ft && |(eff_f & tsel_f))                    hazard = 1'b1;
        if ((iss_rut.from_ef || iss_rut.to_ef) && eff_ef)            hazard = 1'b1;
    end

    assign all_clear  = ~(|eff_g) & ~(|eff_f) & ~eff_ef;
    assign iss_ready  = (state_q == ST_RUN) & ~hazard & (~iss_serial | all_clear);
    assign issue_fire = iss_valid & iss_ready & ~flush;

    // Next state: flush clear > issue set > writeback clear.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pend_g_d  = pend_g_q;
        pend_f_d  = pend_f_q;
        pend_ef_d = pend_ef_q;
        stall_d   = stall_q;

        if (iss_valid && !iss_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end

        if (flush) begin
            state_d   = ST_FLUSH;
            timer_d   = TMR_W'(FLUSH_CYC);
            pend_g_d  = '0;
            pend_f_d  = '0;
            pend_ef_d = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    pend_g_d  = eff_g;
                    pend_f_d  = eff_f;
                    pend_ef_d = eff_ef;
                    if (issue_fire) begin
                        if (iss_rut.to_gd) pend_g_d = pend_g_d | dsel_g;
                        if (iss_rut.to_fd) pend_f_d = pend_f_d | dsel_f;
                        if (iss_rut.to_ef) pend_ef_d = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Writebacks are ignored; nothing is pending in this state.
                    if (timer_q <= TMR_W'(1)) begin
                        state_d = ST_RUN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    timer_d = '0;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            timer_q   <= '0;
            pend_g_q  <= '0;
            pend_f_q  <= '0;
            pend_ef_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pend_g_q  <= pend_g_d;
            pend_f_q  <= pend_f_d;
            pend_ef_q <= pend_ef_d;
            stall_q   <= stall_d;
        end
    end

    assign busy_g    = pend_g_q;
    assign busy_f    = pend_f_q;
    assign busy_ef   = pend_ef_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: table of per-cycle vectors plus
// hand-written saturation and async-reset sequences.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam logic [9:0] FROM_GD = 10'h200;
    localparam logic [9:0] FROM_FD = 10'h100;
    localparam logic [9:0] TO_GD   = 10'h080;
    localparam logic [9:0] TO_FD   = 10'h040;
    localparam logic [9:0] FROM_GS = 10'h020;
    localparam logic [9:0] FROM_FS = 10'h010;
    localparam logic [9:0] FROM_GT = 10'h008;
    localparam logic [9:0] FROM_FT = 10'h004;
    localparam logic [9:0] FROM_EF = 10'h002;
    localparam logic [9:0] TO_EF   = 10'h001;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    rut_t        iss_rut;
    logic        iss_serial;
    logic        iss_ready;
    logic        wb_g_valid;
    logic [3:0]  wb_g_idx;
    logic        wb_f_valid;
    logic [3:0]  wb_f_idx;
    logic        wb_ef_valid;
    logic        flush;
    logic [15:0] busy_g;
    logic [15:0] busy_f;
    logic        busy_ef;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .iss_valid  (iss_valid),
        .iss_rut    (iss_rut),
        .iss_serial (iss_serial),
        .iss_ready  (iss_ready),
        .wb_g_valid (wb_g_valid),
        .wb_g_idx   (wb_g_idx),
        .wb_f_valid (wb_f_valid),
        .wb_f_idx   (wb_f_idx),
        .wb_ef_valid(wb_ef_valid),
        .flush      (flush),
        .busy_g     (busy_g),
        .busy_f     (busy_f),
        .busy_ef    (busy_ef),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        rut_t        rut;
        logic        serial;
        logic        wbg_v;
        logic [3:0]  wbg_idx;
        logic        wbf_v;
        logic [3:0]  wbf_idx;
        logic        wbef;
        logic        fl;
        logic        exp_ready;
        logic [15:0] exp_bg;
        logic [15:0] exp_bf;
        logic        exp_bef;
        logic [31:0] exp_stall;
    } vec_t;

    vec_t vq[$];

    function automatic rut_t mkr(input logic [9:0] fl, input int unsigned d,
                                 input int unsigned s, input int unsigned t);
        rut_t r;
        r.d = 5'(d);
        r.s = 5'(s);
        r.t = 5'(t);
        {r.from_gd, r.from_fd, r.to_gd, r.to_fd, r.from_gs, r.from_fs,
         r.from_gt, r.from_ft, r.from_ef, r.to_ef} = fl;
        return r;
    endfunction

    task automatic add(input logic v, input rut_t r, input logic ser,
                       input logic gv, input int unsigned gi,
                       input logic fv, input int unsigned fi,
                       input logic ef, input logic fl,
                       input logic rdy, input logic [15:0] bg,
                       input logic [15:0] bf, input logic bef,
                       input logic [31:0] st);
        vec_t x;
        x.valid = v; x.rut = r; x.serial = ser;
        x.wbg_v = gv; x.wbg_idx = 4'(gi); x.wbf_v = fv; x.wbf_idx = 4'(fi);
        x.wbef = ef; x.fl = fl;
        x.exp_ready = rdy; x.exp_bg = bg; x.exp_bf = bf; x.exp_bef = bef;
        x.exp_stall = st;
        vq.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_rut = '0; iss_serial = 1'b0;
        wb_g_valid = 1'b0; wb_g_idx = '0; wb_f_valid = 1'b0; wb_f_idx = '0;
        wb_ef_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rut_t r0;
        r0 = '0;
        rst = 1'b1;
        idle_inputs();

        //  v  rut                          ser gv gi fv fi ef fl | rdy bg       bf       bef stall
        add(0, r0,                          0,  0, 0, 0, 0, 0, 0,   1, 16'h0000, 16'h0000, 0, 0);  // 0
        add(1, mkr(TO_GD, 3, 0, 0),         0,  0, 0, 0, 0, 0, 0,   1, 16'h0000, 16'h0000, 0, 0);  // ADD g3
        add(1, mkr(TO_GD|FROM_GS, 4, 3, 0), 0,  0, 0, 0, 0, 0, 0,   0, 16'h0008, 16'h0000, 0, 0);  // SUB RAW
        add(1, mkr(TO_GD|FROM_GS, 4, 3, 0), 0,  0, 0, 0, 0, 0, 0,   0, 16'h0008, 16'h0000, 0, 1);
        add(1, mkr(TO_GD|FROM_GS, 4, 3, 0), 0,  1, 3, 0, 0, 0, 0,   1, 16'h0008, 16'h0000, 0, 2);  // wb bypass
        add(1, mkr(TO_GD, 5, 0, 0),         0,  0, 0, 0, 0, 0, 0,   1, 16'h0010, 16'h0000, 0, 2);
        add(1, mkr(TO_GD, 5, 0, 0),         0,  1, 5, 0, 0, 0, 0,   1, 16'h0030, 16'h0000, 0, 2);  // set+clear same reg
        add(0, r0,                          0,  1, 4, 0, 0, 0, 0,   1, 16'h0030, 16'h0000, 0, 2);
        add(0, r0,                          0,  1, 5, 0, 0, 0, 0,   1, 16'h0020, 16'h0000, 0, 2);
        add(1, mkr(TO_EF, 0, 0, 0),         0,  0, 0, 0, 0, 0, 0,   1, 16'h0000, 16'h0000, 0, 2);  // CMP
        add(1, mkr(FROM_EF, 0, 0, 0),       0,  0, 0, 0, 0, 0, 0,   0, 16'h0000, 16'h0000, 1, 2);  // JE
        add(1, mkr(FROM_EF, 0, 0, 0),       0,  0, 0, 0, 0, 1, 0,   1, 16'h0000, 16'h0000, 1, 3);
        add(1, mkr(TO_GD, 2, 0, 0),         0,  0, 0, 0, 0, 0, 0,   1, 16'h0000, 16'h0000, 0, 3);
        add(1, mkr(TO_FD, 7, 0, 0),         0,  0, 0, 0, 0, 0, 0,   1, 16'h0004, 16'h0000, 0, 3);
        add(1, r0,                          1,  0, 0, 0, 0, 0, 0,   0, 16'h0004, 16'h0080, 0, 3);  // serial
        add(1, r0,                          1,  1, 2, 0, 0, 0, 0,   0, 16'h0004, 16'h0080, 0, 4);
        add(1, r0,                          1,  0, 0, 1, 7, 0, 0,   1, 16'h0000, 16'h0080, 0, 5);
        add(0, r0,                          0,  1, 9, 0, 0, 0, 0,   1, 16'h0000, 16'h0000, 0, 5);  // stray wb
        add(1, mkr(TO_GD, 1, 0, 0),         0,  0, 0, 0, 0, 0, 0,   1, 16'h0000, 16'h0000, 0, 5);
        add(1, mkr(TO_GD|TO_EF, 2, 0, 0),   0,  0, 0, 0, 0, 0, 0,   1, 16'h0002, 16'h0000, 0, 5);
        add(1, mkr(TO_GD, 9, 0, 0),         0,  0, 0, 0, 0, 0, 1,   1, 16'h0006, 16'h0000, 1, 5);  // flush
        add(1, mkr(TO_GD, 9, 0, 0),         0,  0, 0, 0, 0, 0, 0,   0, 16'h0000, 16'h0000, 0, 5);
        add(1, mkr(TO_GD, 9, 0, 0),         0,  0, 0, 0, 0, 0, 0,   0, 16'h0000, 16'h0000, 0, 6);
        add(0, r0,                          0,  0, 0, 0, 0, 0, 0,   1, 16'h0000, 16'h0000, 0, 7);
        add(0, r0,                          0,  0, 0, 0, 0, 0, 1,   1, 16'h0000, 16'h0000, 0, 7);  // flush
        add(1, r0,                          0,  0, 0, 0, 0, 0, 1,   0, 16'h0000, 16'h0000, 0, 7);  // reflush
        add(1, r0,                          0,  0, 0, 0, 0, 0, 0,   0, 16'h0000, 16'h0000, 0, 8);
        add(1, r0,                          0,  0, 0, 0, 0, 0, 0,   0, 16'h0000, 16'h0000, 0, 9);
        add(0, r0,                          0,  0, 0, 0, 0, 0, 0,   1, 16'h0000, 16'h0000, 0, 10);
        add(1, mkr(TO_FD, 3, 0, 0),         0,  0, 0, 0, 0, 0, 0,   1, 16'h0000, 16'h0000, 0, 10);
        add(1, mkr(TO_FD|FROM_FT, 4, 0, 3), 0,  0, 0, 0, 0, 0, 0,   0, 16'h0000, 16'h0008, 0, 10);
        add(1, mkr(TO_FD|FROM_FT, 4, 0, 3), 0,  0, 0, 1, 3, 0, 0,   1, 16'h0000, 16'h0008, 0, 11);
        add(0, r0,                          0,  0, 0, 0, 0, 0, 0,   1, 16'h0000, 16'h0010, 0, 11);
        add(0, r0,                          0,  0, 0, 1, 4, 0, 0,   1, 16'h0000, 16'h0010, 0, 11);
        add(0, r0,                          0,  0, 0, 0, 0, 0, 0,   1, 16'h0000, 16'h0000, 0, 11);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy_g", 32'(busy_g), 32'h0);
        chk("rst_busy_f", 32'(busy_f), 32'h0);
        chk("rst_busy_ef", 32'(busy_ef), 32'h0);
        chk("rst_stall", stall_cnt, 32'h0);
        chk("rst_ready", 32'(iss_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[k]) begin
            @(negedge clk);
            iss_valid = vq[k].valid; iss_rut = vq[k].rut; iss_serial = vq[k].serial;
            wb_g_valid = vq[k].wbg_v; wb_g_idx = vq[k].wbg_idx;
            wb_f_valid = vq[k].wbf_v; wb_f_idx = vq[k].wbf_idx;
            wb_ef_valid = vq[k].wbef; flush = vq[k].fl;
            #1;
            chk($sformatf("v%0d_ready", k), 32'(iss_ready), 32'(vq[k].exp_ready));
            chk($sformatf("v%0d_busy_g", k), 32'(busy_g), 32'(vq[k].exp_bg));
            chk($sformatf("v%0d_busy_f", k), 32'(busy_f), 32'(vq[k].exp_bf));
            chk($sformatf("v%0d_busy_ef", k), 32'(busy_ef), 32'(vq[k].exp_bef));
            chk($sformatf("v%0d_stall", k), stall_cnt, vq[k].exp_stall);
        end

        // Saturation of stall_cnt
        @(negedge clk);
        idle_inputs();
        iss_valid = 1'b1; iss_rut = mkr(TO_GD, 1, 0, 0);
        @(negedge clk);
        iss_rut = mkr(FROM_GS, 0, 1, 0);
        force dut.stall_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_q;
        #1;
        chk("sat_ready", 32'(iss_ready), 32'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("sat_stall", stall_cnt, 32'hFFFF_FFFF);
        chk("sat_busy_g", 32'(busy_g), 32'h0002);

        // Async reset mid-cycle with pending bits set
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy_g", 32'(busy_g), 32'h0);
        chk("arst_stall", stall_cnt, 32'h0);
        chk("arst_ready", 32'(iss_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        iss_rut = mkr(TO_GD, 6, 0, 0);
        @(negedge clk);
        idle_inputs();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_ready", 32'(iss_ready), 32'h0);
        chk("fl_busy_g", 32'(busy_g), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_fsm_ready", 32'(iss_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_ready", 32'(iss_ready), 32'h1);
        chk("post_rst_stall", stall_cnt, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue-stage interlock for the in-order integer/FP pipeline. Takes the register-usage descriptor (`rut_t`) of the instruction waiting to issue and tracks outstanding writes to general registers, FP registers and EFLAGS. It grants issue only when no RAW or WAW hazard exists, and clears pending state from writeback reports. It also serializes ordering-sensitive ops and runs a fixed-length recovery window after a pipeline flush.

## Interface
Parameters:
- `NGPR`, 16: number of general registers tracked.
- `NFPR`, 16: number of FP registers tracked.
- `IDX_W`, 4: register index width; the low `IDX_W` bits of `rut.d/s/t` are used.
- `FLUSH_CYC`, 2: cycles issue stays blocked after `flush` (1..7).

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `iss_valid` in 1: an instruction is presented for issue.
- `iss_rut` in `rut_t`: usage descriptor: `d,s,t`, `from_gd/fd`, `to_gd/fd`, `from_gs/fs/gt/ft`, `from_ef`, `to_ef`.
- `iss_serial` in 1: presented op must issue only with the scoreboard empty (e.g. OUT, IN, JR).
- `iss_ready` out 1: issue permitted this cycle (combinational).
- `wb_g_valid` in 1, `wb_g_idx` in `IDX_W`: GPR write completed.
- `wb_f_valid` in 1, `wb_f_idx` in `IDX_W`: FPR write completed.
- `wb_ef_valid` in 1: EFLAGS write completed.
- `flush` in 1: kill all in-flight ops.
- `busy_g` out `NGPR`, `busy_f` out `NFPR`, `busy_ef` out 1: registered pending bits.
- `stall_cnt` out 32: saturating count of cycles with `iss_valid & ~iss_ready`.

## Operation
- State: `pend_g[NGPR]`, `pend_f[NFPR]`, `pend_ef`, a 2-state FSM (RUN, FLUSH) and a 3-bit flush timer.
- Effective pending is the registered pending bit with same-cycle writeback cleared. Example: `eff_g[i] = pend_g[i] & ~(wb_g_valid & wb_g_idx==i)`. Writeback bypasses into the hazard check.
- A hazard exists when any of the following holds on effective pending:
  - `from_gd|to_gd` and `eff_g[d]`.
  - `from_fd|to_fd` and `eff_f[d]`.
  - `from_gs` and `eff_g[s]`; `from_fs` and `eff_f[s]`.
  - `from_gt` and `eff_g[t]`; `from_ft` and `eff_f[t]`.
  - `from_ef|to_ef` and `eff_ef`.
- `iss_ready` = state RUN & ~hazard & (~iss_serial | all effective pending zero). It does not depend on `iss_valid`.
- Issue fires on `iss_valid & iss_ready` and sets pending for `d` if `to_gd` or `to_fd`, and sets `pend_ef` if `to_ef`.
- Update precedence per bit: flush clear > issue set > writeback clear. A same-cycle writeback and issue to the same register leave the bit set.
- Writeback to a non-pending register is ignored and is not an error.
- `flush` in any state clears all pending bits, enters FLUSH and loads the timer with `FLUSH_CYC`. An issue fire in the same cycle is discarded.
- In FLUSH the timer decrements each cycle. The FSM returns to RUN in the cycle after the timer reads 1. Writebacks during FLUSH are ignored. A `flush` during FLUSH reloads the timer.
- `stall_cnt` increments while `iss_valid & ~iss_ready`, including FLUSH cycles, and saturates at 0xFFFF_FFFF.

## Timing
- Reset (async assert, deasserts synchronous to `clk`) sets:
  - `pend_*` = 0 and `busy_*` = 0.
  - `stall_cnt` = 0.
  - state RUN, timer 0, so `iss_ready` is 1 for any non-hazard input.
- `iss_ready` is combinational from current state, `iss_rut`, `iss_serial` and writeback inputs: zero-cycle path.
- Pending set by an issue at edge N is visible in `busy_*` after edge N, so a dependent op presented in cycle N+1 sees `iss_ready`=0.
- Writeback in cycle N unblocks a dependent op in the same cycle N.
- A flush asserted in cycle N holds `iss_ready`=0 for cycles N+1 .. N+FLUSH_CYC. `iss_ready` can be 1 again at N+FLUSH_CYC+1.

## Test plan
- Reset then RAW:
  - Issue ADD with `to_gd`, d=3 (cycle 0); `busy_g`=0x0008.
  - Present SUB with `from_gs`, s=3: `iss_ready`=0 until `wb_g_valid`, idx=3.
  - `iss_ready`=1 in that same writeback cycle; `stall_cnt` equals stalled cycles.
- WAW plus same-cycle set/clear: d=5 is pending. In one cycle, writeback idx=5 and issue another `to_gd` d=5. The op issues and `busy_g[5]` stays 1 afterwards.
- EFLAGS chain: issue CMP (`to_ef`), then JE (`from_ef`): stalled until `wb_ef_valid`; `busy_ef` goes 1 → 0.
- Serializing op: g2 and f7 are pending and `iss_serial`=1 with no register hazard. `iss_ready`=0 until both are written back; it rises in the cycle the last writeback arrives.
- Flush: with g1, g2 and ef pending, pulse `flush` with `iss_valid`=1. Expect:
  - All `busy_*`=0 next cycle.
  - `iss_ready`=0 for exactly 2 cycles.
  - A second flush mid-window extends it by 2.
  - No pending bit is set by the discarded issue.
- Async reset mid-operation: assert `rst` between edges with pending bits set. `busy_*`, `stall_cnt` and FSM clear immediately; force `stall_cnt` near 0xFFFF_FFFF earlier and check it saturates.
